usb_attach_ctrl: RTL and testbench

USB full-speed attach/bus-state sequencer in the `clk48` domain, between the PLL and the USB device controller. Delays `USB_PULLUP` until the clock is stable, holds the device core in reset while detached, and classifies the bus into active, bus-reset and suspend from the synchronized D+/D− levels. Owns the pull-up pin, the core reset and the link-state flags.

---
 rtl/usb_attach_ctrl.sv | 171 +++++++++++++++++
 tb/tb_usb_attach_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/usb_attach_ctrl.sv
// USB full-speed attach / bus-state sequencer in the clk48 domain.
// Define USB_ATTACH_SUSPEND_EN to build J-idle suspend detection.
module usb_attach_ctrl #(
    parameter int unsigned ATTACH_DELAY_CYCLES   = 4800,
    parameter int unsigned RESET_DETECT_CYCLES   = 120,
    parameter int unsigned SUSPEND_DETECT_CYCLES = 144000
) (
    input  logic clk48,
    input  logic rst,
    input  logic pll_locked,
    input  logic soft_detach,
    input  logic dp_sync,
    input  logic dn_sync,
    output logic USB_PULLUP,
    output logic usb_rst,
    output logic bus_reset_pulse,
    output logic attached,
    output logic suspended
);

    localparam int unsigned CW = $clog2(ATTACH_DELAY_CYCLES + 1);
    localparam int unsigned RW = $clog2(RESET_DETECT_CYCLES + 1);

    typedef enum logic [2:0] {
        DETACHED,
        ATTACH_WAIT,
        ATTACHED,
        BUS_RESET
`ifdef USB_ATTACH_SUSPEND_EN
        , SUSPENDED
`endif
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] se0_cnt;
    logic          se0;
    logic          abort;

    logic pullup_d;
    logic usb_rst_d;
    logic pulse_d;
    logic susp_d;

    assign se0   = !dp_sync && !dn_sync;
    assign abort = !pll_locked || soft_detach;

`ifdef USB_ATTACH_SUSPEND_EN
    localparam int unsigned SW = $clog2(SUSPEND_DETECT_CYCLES + 1);
    logic [SW-1:0] idle_cnt;
    logic          j_line;
    assign j_line = dp_sync && !dn_sync;
`else
    logic [31:0] unused_suspend_cfg;
    assign unused_suspend_cfg = SUSPEND_DETECT_CYCLES;
`endif

    always_ff @(posedge clk48) begin
        if (rst) state <= DETACHED;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = DETACHED;
        end else begin
            case (state)
                DETACHED:    next_state = ATTACH_WAIT;
                ATTACH_WAIT: if (cnt == CW'(ATTACH_DELAY_CYCLES - 1)) next_state = ATTACHED;
                ATTACHED: begin
                    if (se0 && se0_cnt == RW'(RESET_DETECT_CYCLES - 1))
                        next_state = BUS_RESET;
`ifdef USB_ATTACH_SUSPEND_EN
                    else if (j_line && idle_cnt == SW'(SUSPEND_DETECT_CYCLES - 1))
                        next_state = SUSPENDED;
`endif
                end
                BUS_RESET:   if (!se0) next_state = ATTACHED;
`ifdef USB_ATTACH_SUSPEND_EN
                SUSPENDED:   if (!j_line) next_state = ATTACHED;
`endif
                default:     next_state = DETACHED;
            endcase
        end
    end

    // Line counters run in ATTACHED; in SUSPENDED se0_cnt keeps tracking so an
    // SE0 that wakes the bus already counts toward reset detection.
    always_ff @(posedge clk48) begin
        if (rst) begin
            cnt     <= '0;
            se0_cnt <= '0;
`ifdef USB_ATTACH_SUSPEND_EN
            idle_cnt <= '0;
`endif
        end else begin
            case (state)
                DETACHED: cnt <= '0;
                ATTACH_WAIT: begin
                    cnt     <= cnt + CW'(1);
                    se0_cnt <= '0;
`ifdef USB_ATTACH_SUSPEND_EN
                    idle_cnt <= '0;
`endif
                end
                ATTACHED: begin
                    se0_cnt <= se0 ? se0_cnt + RW'(1) : '0;
`ifdef USB_ATTACH_SUSPEND_EN
                    idle_cnt <= j_line ? idle_cnt + SW'(1) : '0;
`endif
                end
                BUS_RESET: begin
                    se0_cnt <= '0;
`ifdef USB_ATTACH_SUSPEND_EN
                    idle_cnt <= '0;
`endif
                end
`ifdef USB_ATTACH_SUSPEND_EN
                SUSPENDED: begin
                    se0_cnt  <= se0 ? se0_cnt + RW'(1) : '0;
                    idle_cnt <= '0;
                end
`endif
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        pullup_d  = 1'b0;
        usb_rst_d = 1'b0;
        pulse_d   = 1'b0;
        susp_d    = 1'b0;
        case (next_state)
            DETACHED:    usb_rst_d = 1'b1;
            ATTACH_WAIT: usb_rst_d = 1'b1;
            ATTACHED:    pullup_d  = 1'b1;
            BUS_RESET: begin
                pullup_d  = 1'b1;
                usb_rst_d = 1'b1;
                pulse_d   = (state != BUS_RESET);
            end
`ifdef USB_ATTACH_SUSPEND_EN
            SUSPENDED: begin
                pullup_d = 1'b1;
                susp_d   = 1'b1;
            end
`endif
            default:     usb_rst_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            USB_PULLUP      <= 1'b0;
            attached        <= 1'b0;
            usb_rst         <= 1'b1;
            bus_reset_pulse <= 1'b0;
            suspended       <= 1'b0;
        end else begin
            USB_PULLUP      <= pullup_d;
            attached        <= pullup_d;
            usb_rst         <= usb_rst_d;
            bus_reset_pulse <= pulse_d;
            suspended       <= susp_d;
        end
    end

endmodule

// File: tb/tb_usb_attach_ctrl.sv
// Randomized bench for usb_attach_ctrl against a run-length reference model.
// Honours USB_ATTACH_SUSPEND_EN in its expectations for the suspended flag.
module tb_usb_attach_ctrl;

    localparam int unsigned AD = 40;
    localparam int unsigned RD = 12;
    localparam int unsigned SD = 50;

    localparam logic [1:0] L_SE0 = 2'b00;
    localparam logic [1:0] L_J   = 2'b10;
    localparam logic [1:0] L_K   = 2'b01;
    localparam logic [1:0] L_SE1 = 2'b11;

    logic clk48 = 1'b0;
    logic rst, pll_locked, soft_detach, dp_sync, dn_sync;
    logic USB_PULLUP, usb_rst, bus_reset_pulse, attached, suspended;

    usb_attach_ctrl #(
        .ATTACH_DELAY_CYCLES  (AD),
        .RESET_DETECT_CYCLES  (RD),
        .SUSPEND_DETECT_CYCLES(SD)
    ) dut (
        .clk48          (clk48),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .soft_detach    (soft_detach),
        .dp_sync        (dp_sync),
        .dn_sync        (dn_sync),
        .USB_PULLUP     (USB_PULLUP),
        .usb_rst        (usb_rst),
        .bus_reset_pulse(bus_reset_pulse),
        .attached       (attached),
        .suspended      (suspended)
    );

    always #5 clk48 = ~clk48;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference: -1 = off the bus and not counting; >=0 = cycles of clean lock.
    int m_wait;
    bit m_on_bus, m_in_reset, m_in_susp, m_pulse;
    int m_se0_run, m_j_run;

    function automatic void model_reset();
        m_wait = -1; m_on_bus = 0; m_in_reset = 0; m_in_susp = 0; m_pulse = 0;
        m_se0_run = 0; m_j_run = 0;
    endfunction

    function automatic void model_step(input logic lock, input logic det,
                                       input logic dp, input logic dn);
        bit se0, jl, was_reset;
        se0 = !dp && !dn;
        jl  = dp && !dn;
        was_reset = m_in_reset;
        if (!lock || det) begin
            model_reset();
        end else if (!m_on_bus) begin
            m_wait = m_wait + 1;
            if (m_wait == int'(AD)) begin
                m_on_bus = 1; m_se0_run = 0; m_j_run = 0;
            end
        end else if (m_in_reset) begin
            if (!se0) begin
                m_in_reset = 0; m_se0_run = 0; m_j_run = 0;
            end
        end else if (m_in_susp) begin
            if (!jl) begin
                m_in_susp = 0; m_j_run = 0; m_se0_run = se0 ? 1 : 0;
            end
        end else begin
            m_se0_run = se0 ? m_se0_run + 1 : 0;
            m_j_run   = jl  ? m_j_run + 1   : 0;
            if (m_se0_run == int'(RD)) m_in_reset = 1;
`ifdef USB_ATTACH_SUSPEND_EN
            if (m_j_run == int'(SD)) m_in_susp = 1;
`endif
        end
        m_pulse = m_in_reset && !was_reset;
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0b exp %0b", tag, cycle, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk48);
        if (rst) model_reset();
        else     model_step(pll_locked, soft_detach, dp_sync, dn_sync);
        cycle++;
        #1;
        check("pullup",    USB_PULLUP,      m_on_bus);
        check("attached",  attached,        m_on_bus);
        check("usb_rst",   usb_rst,         !m_on_bus || m_in_reset);
        check("rst_pulse", bus_reset_pulse, m_pulse);
        check("suspended", suspended,       m_in_susp);
    endtask

    task automatic run_line(input logic [1:0] sym, input int len);
        {dp_sync, dn_sync} = sym;
        for (int i = 0; i < len; i++) tick();
    endtask

    task automatic abort_pulse(input bit use_lock, input int len);
        if (use_lock) pll_locked = 1'b0;
        else          soft_detach = 1'b1;
        tick();
        for (int i = 1; i < len; i++) tick();
        pll_locked  = 1'b1;
        soft_detach = 1'b0;
    endtask

    int lens[10];
    logic [1:0] syms[4];

    initial begin
        lens = '{1, 2, 3, RD - 1, RD, RD + 3, SD - 1, SD, SD + 2, AD};
        syms = '{L_SE0, L_J, L_K, L_SE1};

        rst = 1'b1; pll_locked = 1'b0; soft_detach = 1'b0;
        {dp_sync, dn_sync} = L_J;
        repeat (3) tick();
        rst = 1'b0;
        pll_locked = 1'b1;

        // Lock glitch mid attach-wait, then full attach.
        run_line(L_J, 30);
        abort_pulse(1'b1, 1);
        run_line(L_J, AD + 4);

        // Short SE0, long SE0, J idle into suspend and K wake.
        run_line(L_SE0, RD - 1);
        run_line(L_J, 3);
        run_line(L_SE0, RD + 8);
        run_line(L_J, SD + 3);
        run_line(L_K, 2);

        // Detach from bus reset, then from suspend.
        run_line(L_SE0, RD + 2);
        abort_pulse(1'b0, 1);
        run_line(L_J, AD + 2);
        run_line(L_J, SD + 2);
        abort_pulse(1'b0, 2);
        run_line(L_J, AD + 2);

        // Wake from suspend directly with SE0 so it counts toward reset.
        run_line(L_J, SD + 1);
        run_line(L_SE0, RD + 1);
        run_line(L_J, 2);

        repeat (260) begin
            if ($urandom_range(0, 15) == 0)
                abort_pulse(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
            run_line(syms[$urandom_range(0, 3)], lens[$urandom_range(0, 9)]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
